// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
//
// Owns the register file's single write port and the debug read path of
// the RV32I 5-stage pipeline. After reset it zeroes x1..x31 (when the
// RF_CLEAR_EN macro is defined), then shares the write port between the
// WB stage (fixed priority) and a debug/loader requester. A starvation
// counter raises pipe_hold so a blocked debug write always gets through.
//
// Build option:
//   RF_CLEAR_EN defined   : x1..x31 are written with zero on 31 edges
//                           after reset before normal operation starts.
//   RF_CLEAR_EN undefined : no clear writes; RUN is entered on the first
//                           edge after reset and the regfile keeps its
//                           own initial contents.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   wb_wer/rd/data    WB stage write request
//   dbg_req/we/addr/wdata  debug request (held until dbg_gnt)
//   dbg_gnt           combinational one-cycle accept pulse
//   dbg_rvalid/rdata  registered read response, cycle after the grant
//   rf_we/waddr/wdata regfile write port (combinational mux)
//   rf_dbg_raddr      regfile debug read address (= dbg_addr)
//   rf_dbg_rdata      regfile debug read data (combinational)
//   init_done         clear sequence finished
//   pipe_hold         freeze request to the pipeline
module regfile_port_ctrl #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wer,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_dbg_raddr,
  input  logic [XLEN-1:0] rf_dbg_rdata,
  output logic            init_done,
  output logic            pipe_hold
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starveNext;
  logic          w_wbActive;
  logic          w_dbgWrPend;
  logic          w_dbgWrGnt;
  logic          w_dbgRdGnt;
  logic          w_bypass;
  logic          w_starveHold;

`ifdef RF_CLEAR_EN
  logic [AW-1:0] r_cnt;
`endif

  // A WB write to x0 is architecturally a no-op, so it does not occupy the port.
  assign w_wbActive   = wb_wer && (wb_rd != '0);
  assign w_dbgWrPend  = dbg_req && dbg_we;
  assign w_starveHold = (r_starve >= SW'(STARVE_MAX));
  // Read-after-write in the grant cycle: return the value WB is committing.
  assign w_bypass     = w_wbActive && (wb_rd == dbg_addr);

  assign rf_dbg_raddr = dbg_addr;
  assign init_done    = (r_state == RUN);
  assign pipe_hold    = !init_done || w_starveHold;

  // CLEAR leaves once the last register has been zeroed; without the clear
  // option it is a single-cycle pass-through into RUN.
  always_comb begin
    w_stateNext = r_state;
    if (r_state == CLEAR) begin
`ifdef RF_CLEAR_EN
      if (r_cnt == {AW{1'b1}}) begin
        w_stateNext = RUN;
      end
`else
      w_stateNext = RUN;
`endif
    end
  end

  // Write-port mux and grant generation. Everything is forced idle while
  // reset is held so the regfile never sees a write during reset.
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    dbg_gnt    = 1'b0;
    w_dbgWrGnt = 1'b0;
    w_dbgRdGnt = 1'b0;
    if (rst_n) begin
      if (r_state == CLEAR) begin
`ifdef RF_CLEAR_EN
        rf_we    = 1'b1;
        rf_waddr = r_cnt;
`endif
      end else begin
        w_dbgRdGnt = dbg_req && !dbg_we;
        w_dbgWrGnt = w_dbgWrPend && !w_wbActive;
        dbg_gnt    = w_dbgRdGnt || w_dbgWrGnt;
        if (w_wbActive) begin
          rf_we    = 1'b1;
          rf_waddr = wb_rd;
          rf_wdata = wb_data;
        end else if (w_dbgWrGnt) begin
          // A debug write to x0 is accepted but never reaches the regfile.
          rf_we    = (dbg_addr != '0);
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
      end
    end
  end

  // Starvation counter: counts consecutive cycles a debug write waits,
  // saturating at STARVE_MAX where it holds the pipeline until the grant.
  always_comb begin
    w_starveNext = r_starve;
    if (!w_dbgWrPend || w_dbgWrGnt) begin
      w_starveNext = '0;
    end else if (!w_starveHold) begin
      w_starveNext = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_starve   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
`ifdef RF_CLEAR_EN
      r_cnt      <= AW'(1);
`endif
    end else begin
      r_state    <= w_stateNext;
      r_starve   <= w_starveNext;
      dbg_rvalid <= w_dbgRdGnt;
      if (w_dbgRdGnt) begin
        dbg_rdata <= w_bypass ? wb_data : rf_dbg_rdata;
      end
`ifdef RF_CLEAR_EN
      if ((r_state == CLEAR) && (r_cnt != {AW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Controller for the register file's single write port and its debug read access in the RV32I 5-stage pipeline. Clears x1..x31 after reset, then shares the write port between the WB stage and a debug/loader requester. WB has fixed priority; a starvation counter requests a pipeline hold so debug traffic always completes. Sits between WB, the debug port, and the regfile write/debug-read ports.

## Interface
- `XLEN`, 32, data width
- `AW`, 5, register address width (32 registers)
- `STARVE_MAX`, 4, consecutive blocked cycles before `pipe_hold` is asserted for a debug write

- `clk` in 1: single core clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_wer` in 1: WB write enable.
- `wb_rd` in AW: WB destination register.
- `wb_data` in XLEN: WB write data.
- `dbg_req` in 1: debug request; held until `dbg_gnt`.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in AW: debug register address.
- `dbg_wdata` in XLEN: debug write data.
- `dbg_gnt` out 1: one-cycle accept pulse.
- `dbg_rvalid` out 1: read data valid, one cycle.
- `dbg_rdata` out XLEN: read data.
- `rf_we` out 1: regfile write enable.
- `rf_waddr` out AW: regfile write address.
- `rf_wdata` out XLEN: regfile write data.
- `rf_dbg_raddr` out AW: regfile debug read address (= `dbg_addr`, combinational).
- `rf_dbg_rdata` in XLEN: regfile debug read data (combinational).
- `init_done` out 1: clear sequence finished.
- `pipe_hold` out 1: freeze request to the pipeline.

## Operation
- States:
  - CLEAR: counter `cnt` runs 1..31. Drives `rf_we`=1, `rf_waddr`=`cnt`, `rf_wdata`=0. WB inputs are ignored and `dbg_req` is not granted. After `cnt`=31 is written, go to RUN.
  - RUN: normal arbitration.
- `rf_*` outputs are a combinational mux of the state and inputs. WB path has zero added latency.
- RUN, WB active (`wb_wer`=1 and `wb_rd`≠0): WB drives the port. A pending debug write is blocked and the starvation counter increments.
- RUN, WB idle, debug write pending: drive `dbg_addr`/`dbg_wdata` on the port and pulse `dbg_gnt`. If `dbg_addr`=0, `rf_we` stays 0 but the grant is still given.
- Debug read (`dbg_we`=0): granted in any RUN cycle, because reads never contend. On that posedge, `dbg_rdata` captures `rf_dbg_rdata`. If WB writes the same nonzero register in the grant cycle, `dbg_rdata` captures `wb_data` instead (bypass).
- Starvation counter:
  - Resets to 0 on grant, or when no debug write is pending.
  - At `STARVE_MAX`, `pipe_hold` is asserted until the grant.
- `pipe_hold` = !`init_done` | starvation hold.
- `rf_we` is never 1 with `rf_waddr`=0.

## Timing
- Reset values, all forced while `rst_n`=0:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0
  - `dbg_gnt`=0, `dbg_rvalid`=0, `dbg_rdata`=0
  - `init_done`=0, `pipe_hold`=1
  - state=CLEAR, `cnt`=1, starve=0
- CLEAR takes 31 posedges after `rst_n` rises. `init_done` rises at the 31st and `pipe_hold` falls in the same cycle, unless a starvation hold applies.
- Debug write: `dbg_gnt` is combinational and coincides with the regfile write edge. Latency is 0 when WB is idle.
- Debug read: `dbg_gnt` in cycle N, `dbg_rvalid`/`dbg_rdata` in cycle N+1.
- Same-register collision (WB and a blocked debug write): WB writes first, debug writes later, so the debug value is final.
- `dbg_req` dropped before `dbg_gnt`: the request is abandoned and starve clears to 0.
- Back-to-back requests: a new grant is allowed in the cycle after `dbg_gnt`.
- Reset mid-CLEAR or mid-request: all state returns to reset values and CLEAR restarts from x1.

## Configuration
- `RF_CLEAR_EN` defined:
  - CLEAR sequence runs as described.
- `RF_CLEAR_EN` undefined:
  - CLEAR is skipped and no clear writes are issued.
  - `init_done` rises at the first posedge after `rst_n` deasserts.
  - State enters RUN directly; the regfile keeps its own initial contents.

## Test plan
- Reset release with `RF_CLEAR_EN` -> `rf_we`=1 with addr 1..31 and data 0 on 31 consecutive edges. `init_done`=1 after the 31st; `pipe_hold` falls.
- RUN, WB idle, debug write x5=0xDEADBEEF -> same-cycle `dbg_gnt`, `rf_we`=1, `rf_waddr`=5. A later debug read of x5 returns 0xDEADBEEF with `dbg_rvalid` one cycle after grant.
- WB writes x7 every cycle while debug write x7=0x1234 is pending -> `pipe_hold`=1 after 4 blocked cycles. Once WB idles, grant occurs and x7 ends at 0x1234.
- Debug read x9 in the same cycle WB writes x9=0xA5A5A5A5 -> `dbg_rdata`=0xA5A5A5A5.
- Debug write to x0 -> `dbg_gnt`=1 and `rf_we`=0; a read of x0 returns 0.
- `rst_n` low at `cnt`=12 -> outputs return to reset values; after release, clearing restarts at x1.
